// File: rtl/bit32_mux_arbiter.sv
// bit32_mux_arbiter: round-robin share of one 32-bit 2:1 mux between
// two valid/ready producers, burst-bounded, with a 1-entry output stage.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   req1_valid/data/ready requester 1 handshake (mux in1)
//   req2_valid/data/ready requester 2 handshake (mux in2)
//   sel                   mux select, 1 only while requester 2 holds grant
//   out_valid/data/ready  registered output handshake
//   busy                  a grant is active
// Build option: ARB_FIXED_PRIO_EN makes requester 1 win every tie and
// lets it keep the grant past BURST; only requester 2 bursts are bounded.

module bit32_mux_arbiter #(
  parameter int BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  input  logic        req2_valid,
  input  logic [31:0] req2_data,
  output logic        req2_ready,
  output logic        sel,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT2 = 2'd2
  } state_t;

  localparam logic [3:0] BLEN = 4'(BURST);

  state_t      state;
  state_t      state_d;
  state_t      oth_st;
  // last: 0 = requester 1 granted most recently, 1 = requester 2
  logic        last;
  logic        last_d;
  logic [3:0]  cnt;
  logic [3:0]  cnt_d;
  logic [3:0]  cnt_inc;

  logic        space;
  logic        xfer1;
  logic        xfer2;
  logic        xfer;
  logic        in_g1;
  logic        own_v;
  logic        oth_v;
  logic        hold;
  logic        drop;
  logic        exp_hit;
  logic        pick2;
  logic        sw1;
  logic        sw_exp;
  logic [31:0] mux_data;

  assign space = !out_valid || out_ready;
  assign xfer1 = req1_valid && req1_ready;
  assign xfer2 = req2_valid && req2_ready;
  assign xfer  = xfer1 || xfer2;

  assign cnt_inc = cnt + {3'b000, xfer};

  assign in_g1  = (state == GNT1);
  assign own_v  = in_g1 ? req1_valid : req2_valid;
  assign oth_v  = in_g1 ? req2_valid : req1_valid;
  assign oth_st = in_g1 ? GNT2 : GNT1;

  // Grant-state decode; the three cases are mutually exclusive.
  // With space high and own valid high a transfer is happening,
  // so the burst test uses the post-transfer count.
  assign hold    = !space;
  assign drop    = space && !own_v;
  assign exp_hit = space && own_v && (cnt_inc == BLEN);

`ifdef ARB_FIXED_PRIO_EN
  assign pick2 = req2_valid && !req1_valid;
  assign sw1   = 1'b0;
`else
  assign pick2 = req2_valid && (!req1_valid || !last);
  assign sw1   = req2_valid;
`endif

  // Requester 1 always takes over an expired requester 2 burst.
  assign sw_exp = in_g1 ? sw1 : req1_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_d;
      last  <= last_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    last_d  = last;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (req1_valid || req2_valid) begin
          state_d = pick2 ? GNT2 : GNT1;
          last_d  = pick2;
          cnt_d   = '0;
        end
      end
      GNT1, GNT2: begin
        unique case (1'b1)
          hold: cnt_d = cnt;
          drop: begin
            cnt_d = '0;
            if (oth_v) begin
              state_d = oth_st;
              last_d  = in_g1;
            end else begin
              state_d = IDLE;
            end
          end
          exp_hit: begin
            cnt_d = '0;
            if (sw_exp) begin
              state_d = oth_st;
              last_d  = in_g1;
            end
          end
          default: cnt_d = cnt_inc;
        endcase
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Readies are gated by rst_n so nothing is accepted in a reset cycle.
  always_comb begin
    sel        = 1'b0;
    busy       = 1'b0;
    req1_ready = 1'b0;
    req2_ready = 1'b0;
    unique case (state)
      GNT1: begin
        busy       = 1'b1;
        req1_ready = space && rst_n;
      end
      GNT2: begin
        busy       = 1'b1;
        sel        = 1'b1;
        req2_ready = space && rst_n;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign mux_data = sel ? req2_data : req1_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  a_one_ready: assert property (
    @(posedge clk) !(req1_ready && req2_ready));

  a_out_hold: assert property (
    @(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));
`endif

endmodule

// File: tb/tb_bit32_mux_arbiter.sv
// tb_bit32_mux_arbiter: scoreboard bench for bit32_mux_arbiter.
// Producers are word queues; expected output order is queued up front.

module tb_bit32_mux_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req1_valid;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        req2_valid;
  logic [31:0] req2_data;
  logic        req2_ready;
  logic        sel;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        busy;

  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic [31:0] sb[$];

  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   first_out = -1;
  int   last_out  = -1;
  int   base      = 0;
  logic rst_q     = 1'b0;
  logic ordy      = 1'b1;
  logic sel_seen  = 1'b0;

  always #5 clk = ~clk;

  bit32_mux_arbiter #(
    .BURST(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .req2_valid(req2_valid),
    .req2_data (req2_data),
    .req2_ready(req2_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic drive();
    rst_n      = rst_q;
    out_ready  = ordy;
    req1_valid = (q1.size() != 0);
    req1_data  = (q1.size() != 0) ? q1[0] : 32'h0;
    req2_valid = (q2.size() != 0);
    req2_data  = (q2.size() != 0) ? q2[0] : 32'h0;
  endtask

  task automatic observe();
    if (rst_n !== 1'b1) return;
    if (sel === 1'b1) sel_seen = 1'b1;
    if (req1_valid && req1_ready === 1'b1) void'(q1.pop_front());
    if (req2_valid && req2_ready === 1'b1) void'(q2.pop_front());
    if (out_valid === 1'b1 && out_ready) begin
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
      check("sb_has_word", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check("out_data", out_data, sb.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    cyc++;
    observe();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run(input string tag, input int max);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
    idle(3);
  endtask

  task automatic do_reset();
    rst_q = 1'b0;
    ordy  = 1'b1;
    q1.delete();
    q2.delete();
    sb.delete();
    tick();
    tick();
    rst_q     = 1'b1;
    sel_seen  = 1'b0;
    first_out = -1;
  endtask

  initial begin
    rst_n      = 1'b0;
    out_ready  = 1'b1;
    req1_valid = 1'b0;
    req1_data  = 32'h0;
    req2_valid = 1'b0;
    req2_data  = 32'h0;

    // Reset values
    do_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req1_ready", 32'(req1_ready), 32'd0);
    check("rst_req2_ready", 32'(req2_ready), 32'd0);

    // Single requester stream: one bubble then 8 back-to-back words
    for (int i = 0; i < 8; i++) begin
      q1.push_back(32'h1111_0000 + 32'(i));
      sb.push_back(32'h1111_0000 + 32'(i));
    end
    base = cyc;
    tick();
    check("t1_bubble_ready", 32'(req1_ready), 32'd0);
    check("t1_bubble_busy", 32'(busy), 32'd0);
    tick();
    check("t1_grant_ready", 32'(req1_ready), 32'd1);
    check("t1_grant_busy", 32'(busy), 32'd1);
    run("t1", 20);
    check("t1_latency", 32'(first_out - base), 32'd3);
    check("t1_back2back", 32'(last_out - first_out), 32'd7);
    check("t1_sel_low", 32'(sel_seen), 32'd0);

    // Both requesters always valid
    do_reset();
    for (int i = 0; i < 16; i++) begin
      q1.push_back(32'hA100_0000 + 32'(i));
      q2.push_back(32'hB200_0000 + 32'(i));
    end
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < 16; i++) sb.push_back(32'hA100_0000 + 32'(i));
    for (int i = 0; i < 16; i++) sb.push_back(32'hB200_0000 + 32'(i));
`else
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++)
        sb.push_back(32'hA100_0000 + 32'(4 * k + j));
      for (int j = 0; j < 4; j++)
        sb.push_back(32'hB200_0000 + 32'(4 * k + j));
    end
`endif
    base = cyc;
    run("t2", 60);
    check("t2_latency", 32'(first_out - base), 32'd3);
`ifdef ARB_FIXED_PRIO_EN
    check("t2_span", 32'(last_out - first_out), 32'd32);
`else
    check("t2_span", 32'(last_out - first_out), 32'd31);
`endif

    // Output stall holds the word and blocks both requesters
    do_reset();
    ordy = 1'b0;
    q1.push_back(32'hDEAD_BEEF);
    q1.push_back(32'h0000_0001);
    q1.push_back(32'h0000_0002);
    q2.push_back(32'hC0FF_EE00);
    sb.push_back(32'hDEAD_BEEF);
    sb.push_back(32'h0000_0001);
    sb.push_back(32'h0000_0002);
    sb.push_back(32'hC0FF_EE00);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid === 1'b1) break;
    end
    check("t3_stall_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (i != 0) tick();
      check("t3_hold_data", out_data, 32'hDEAD_BEEF);
      check("t3_req1_ready", 32'(req1_ready), 32'd0);
      check("t3_req2_ready", 32'(req2_ready), 32'd0);
    end
    ordy = 1'b1;
    run("t3", 30);

    // Requester 1 drops after 2 words; requester 2 gets a fresh burst
    do_reset();
    q1.push_back(32'hC100_0000);
    q1.push_back(32'hC100_0001);
    for (int i = 0; i < 6; i++)
      q2.push_back(32'hC200_0000 + 32'(i));
    sb.push_back(32'hC100_0000);
    sb.push_back(32'hC100_0001);
    for (int i = 0; i < 4; i++)
      sb.push_back(32'hC200_0000 + 32'(i));
    for (int i = 2; i < 5; i++)
      sb.push_back(32'hC100_0000 + 32'(i));
    sb.push_back(32'hC200_0004);
    sb.push_back(32'hC200_0005);
    for (int i = 0; i < 10 && q1.size() != 0; i++) tick();
    check("t4_r1_sent", 32'(q1.size()), 32'd0);
    tick();
    for (int i = 2; i < 5; i++)
      q1.push_back(32'hC100_0000 + 32'(i));
    tick();
    check("t4_sel_gnt2", 32'(sel), 32'd1);
    check("t4_req2_ready", 32'(req2_ready), 32'd1);
    check("t4_req1_ready", 32'(req1_ready), 32'd0);
    run("t4", 40);

    // Reset mid-burst, then first tie goes to requester 1
    do_reset();
    for (int i = 0; i < 8; i++) begin
      q1.push_back(32'h5A00_0000 + 32'(i));
      q2.push_back(32'h5B00_0000 + 32'(i));
      sb.push_back(32'h5A00_0000 + 32'(i));
    end
    idle(4);
    rst_q = 1'b0;
    tick();
    check("t5_rst_req1_ready", 32'(req1_ready), 32'd0);
    check("t5_rst_req2_ready", 32'(req2_ready), 32'd0);
    rst_q = 1'b1;
    q1.delete();
    q2.delete();
    sb.delete();
    tick();
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_sel", 32'(sel), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_out_data", out_data, 32'h0);
    q1.push_back(32'h5555_5555);
    q2.push_back(32'h6666_6666);
    sb.push_back(32'h5555_5555);
    sb.push_back(32'h6666_6666);
    run("t5", 20);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/bit32_mux_arbiter.md
# bit32_mux_arbiter

Round-robin arbiter that shares one 32-bit 2:1 mux datapath between two requesters with valid/ready handshakes. It drives the mux select from its grant state, bounds each grant to a configurable burst length, and registers the selected word into a single-entry output stage with its own valid/ready handshake. It sits between two 32-bit producers and one consumer wherever the team time-shares a 32-bit bus.

## Interface
- BURST, 4: max consecutive transfers per grant while the other requester is waiting; legal range 1..15.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  32  requester 1 word; mux in1.
- req1_ready  output  1  requester 1 word accepted this cycle.
- req2_valid  input  1  requester 2 has a word.
- req2_data  input  32  requester 2 word; mux in2.
- req2_ready  output  1  requester 2 word accepted this cycle.
- sel  output  1  mux select; 0 = in1, 1 = in2.
- out_valid  output  1  out_data holds a word.
- out_data  output  32  registered mux output.
- out_ready  input  1  consumer accepts out_data.
- busy  output  1  state is not IDLE.

## Operation
- States: IDLE, GNT1, GNT2. Grant pointer `last` (1 or 2) records the most recently granted requester. Burst counter `cnt` is 4 bits.
- sel = 1 only in GNT2; otherwise 0. busy = (state != IDLE).
- space = !out_valid || out_ready.
- reqN_ready = (state == GNTN) && space && rst_n.
- A transfer on requester N occurs when reqN_valid && reqN_ready. On a transfer, out_data <= reqN_data (through the mux), out_valid <= 1, and cnt <= cnt + 1.
- out_valid clears when out_valid && out_ready and no transfer occurs in the same cycle. Simultaneous drain and load keeps out_valid = 1 with the new word.
- IDLE:
  - Only one requester valid: grant it.
  - Both valid: grant the requester other than `last`.
  - Neither valid: stay in IDLE.
  - On any grant: cnt <= 0 and `last` <= the granted requester.
- GNTN, evaluated at each edge after counting any transfer in that cycle:
  - reqN_valid low while space is high (requester idle): if the other requester is valid, go to GNT(other) with cnt <= 0 and `last` updated; else go to IDLE.
  - cnt reaches BURST: if the other requester is valid, go to GNT(other) with cnt <= 0; else stay in GNTN with cnt <= 0.
  - Otherwise stay in GNTN.
- The grant never changes while the output stage is stalled (space low). A requester whose valid drops during a stall keeps the grant.
- Reset values: state IDLE, `last` = 2 (so requester 1 wins the first tie), cnt 0, out_valid 0, out_data 0, sel 0, req1_ready 0, req2_ready 0, busy 0.

## Timing
- Latency from transfer to out_valid: 1 cycle.
- IDLE to first transfer: 1 cycle after the first valid is seen (one bubble).
- GNT1 to GNT2 switch: no bubble; the cycle after the last GNT1 transfer may carry a GNT2 transfer.
- Sustained throughput: 1 word/cycle while out_ready is held high.
- Reset mid-operation: readies are forced to 0 in any cycle where rst_n is low, so no transfer completes. The output word held at that point is discarded, and all outputs reach their reset values at the edge.
- out_data is stable while out_valid && !out_ready.

## Configuration
- ARB_FIXED_PRIO_EN
  - Defined: requester 1 always wins ties in IDLE and on burst expiry, and `last` is ignored. On burst expiry in GNT1, the grant stays with requester 1 even if requester 2 is waiting; BURST limits only GNT2 bursts.
  - Undefined: round-robin exactly as described under Operation.

## Test plan
- Reset, then hold req1_valid with data 0x11110000..0x11110007, out_ready = 1 → 1 idle bubble, then 8 words on consecutive cycles in order; sel stays 0.
- Both requesters always valid, BURST = 4, out_ready = 1 → output pattern is 4 words from requester 1, then 4 from requester 2, repeating, with no bubbles; sel toggles every 4 transfers.
- out_ready low for 3 cycles while out_valid = 1 with word 0xDEADBEEF → out_data holds 0xDEADBEEF, both readies are 0, and no words are lost or duplicated after release.
- Requester 1 drops req1_valid after 2 words while requester 2 is valid → GNT2 on the next edge; cnt restarts, so requester 2 gets up to 4 words.
- rst_n low for 1 cycle mid-burst → next cycle shows out_valid = 0, sel = 0, busy = 0; the first tie after reset goes to requester 1.
- With ARB_FIXED_PRIO_EN defined and both requesters valid → requester 1 holds the grant indefinitely; requester 2 is served only while req1_valid is low.
